vga_fb_scanout: RTL and testbench

//  Parametrised single-clock VGA scan-out engine for the gobang display: timing generator,
//  on-chip framebuffer with independent write port, integer pixel scaling and a board-cell

---
 rtl/vga_fb_scanout_pkg.sv | 20 ++
 rtl/vga_fb_scanout_if.sv | 27 ++
 rtl/vga_fb_scanout_fb_ram.sv | 25 ++
 rtl/vga_fb_scanout.sv | 164 ++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_scanout_pkg.sv
// rtl/vga_fb_scanout_pkg.sv - colour type, VGA timing presets and timing helper functions
package vga_fb_scanout_pkg;

  localparam int CW_DEF = 12;
  typedef logic [CW_DEF-1:0] color_t;

  localparam int H_ACT_800 = 800, H_FP_800 = 56, H_SYN_800 = 120, H_BP_800 = 64;
  localparam int V_ACT_600 = 600, V_FP_600 = 37, V_SYN_600 = 6,   V_BP_600 = 23;
  localparam int H_ACT_640 = 640, H_FP_640 = 16, H_SYN_640 = 96,  H_BP_640 = 48;
  localparam int V_ACT_480 = 480, V_FP_480 = 10, V_SYN_480 = 2,   V_BP_480 = 33;

  function automatic int line_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic logic in_sync(input int pos, input int act, input int fp, input int syn);
    return (pos >= act + fp) && (pos < act + fp + syn);
  endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// rtl/vga_fb_scanout_if.sv - framebuffer write, cursor control and video output bundle
interface vga_fb_scanout_if #(
  parameter int CW = 12,
  parameter int AW = 15
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;
  logic          cursor_en;
  logic [7:0]    cursor_x;
  logic [7:0]    cursor_y;
  logic          hs;
  logic          vs;
  logic          de;
  logic [CW-1:0] rgb;
  logic          frame_start;

  modport master (
    output we, waddr, wdata, cursor_en, cursor_x, cursor_y,
    input  hs, vs, de, rgb, frame_start
  );

  modport slave (
    input  we, waddr, wdata, cursor_en, cursor_x, cursor_y,
    output hs, vs, de, rgb, frame_start
  );
endinterface

// File: rtl/vga_fb_scanout_fb_ram.sv
// rtl/vga_fb_scanout_fb_ram.sv - simple dual-port framebuffer, read-first, registered read
module fb_ram #(
  parameter int DW    = 12,
  parameter int AW    = 15,
  parameter int DEPTH = 30000
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Both ports use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) r_mem[waddr] <= wdata;
    if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;
endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - single-clock VGA scan-out: timing, scaled framebuffer read, cursor overlay
module vga_fb_scanout
  import vga_fb_scanout_pkg::*;
#(
  parameter int CW       = 12,
  parameter int AW       = 15,
  parameter int FB_W     = 200,
  parameter int FB_H     = 150,
  parameter int SCALE_SH = 2,
  parameter int CELL_SH  = 3,
  parameter int H_ACT    = H_ACT_800,
  parameter int H_FP     = H_FP_800,
  parameter int H_SYN    = H_SYN_800,
  parameter int H_BP     = H_BP_800,
  parameter int V_ACT    = V_ACT_600,
  parameter int V_FP     = V_FP_600,
  parameter int V_SYN    = V_SYN_600,
  parameter int V_BP     = V_BP_600,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter logic [CW-1:0] BG_COLOR  = '0,
  parameter logic [CW-1:0] CUR_COLOR = CW'(12'hF00)
) (
  input logic             clk,
  input logic             rstn,
  input logic             pix_ce,
  vga_fb_scanout_if.slave bus
);
  localparam int H_TOTAL = line_total(H_ACT, H_FP, H_SYN, H_BP);
  localparam int V_TOTAL = line_total(V_ACT, V_FP, V_SYN, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [HW-1:0] w_fx;
  logic [VW-1:0] w_fy;
  logic [AW-1:0] w_raddr;
  logic          w_in_fb, w_de, w_hs, w_vs, w_origin;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_ce) begin
      if (int'(r_h) == H_TOTAL - 1) begin
        r_h <= '0;
        r_v <= (int'(r_v) == V_TOTAL - 1) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // S0: scaled fb coordinates and RAM address straight off the counters
  always_comb begin
    w_fx     = r_h >> SCALE_SH;
    w_fy     = r_v >> SCALE_SH;
    w_in_fb  = (int'(w_fx) < FB_W) && (int'(w_fy) < FB_H);
    w_raddr  = w_in_fb ? AW'(int'(w_fy) * FB_W + int'(w_fx)) : '0;
    w_de     = (int'(r_h) < H_ACT) && (int'(r_v) < V_ACT);
    w_hs     = in_sync(int'(r_h), H_ACT, H_FP, H_SYN);
    w_vs     = in_sync(int'(r_v), V_ACT, V_FP, V_SYN);
    w_origin = (r_h == '0) && (r_v == '0);
  end

  logic          r_s1_de, r_s1_hs, r_s1_vs, r_s1_in_fb, r_s1_origin;
  logic [HW-1:0] r_s1_fx;
  logic [VW-1:0] r_s1_fy;
  logic          r_cur_en;
  logic [7:0]    r_cur_x, r_cur_y;
  logic [CW-1:0] w_rdata;

  // Cursor registers reload with pixel (0,0) so the whole frame sees one position.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_de     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_in_fb  <= 1'b0;
      r_s1_origin <= 1'b0;
      r_s1_fx     <= '0;
      r_s1_fy     <= '0;
      r_cur_en    <= 1'b0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
    end else if (pix_ce) begin
      r_s1_de     <= w_de;
      r_s1_hs     <= w_hs;
      r_s1_vs     <= w_vs;
      r_s1_in_fb  <= w_in_fb;
      r_s1_origin <= w_origin;
      r_s1_fx     <= w_fx;
      r_s1_fy     <= w_fy;
      if (w_origin) begin
        r_cur_en <= bus.cursor_en;
        r_cur_x  <= bus.cursor_x;
        r_cur_y  <= bus.cursor_y;
      end
    end
  end

  fb_ram #(
    .DW    (CW),
    .AW    (AW),
    .DEPTH (FB_W * FB_H)
  ) u_fb_ram (
    .clk   (clk),
    .we    (bus.we),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .re    (pix_ce),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  logic [HW-1:0]      w_cell_x;
  logic [VW-1:0]      w_cell_y;
  logic [CELL_SH-1:0] w_sub_x, w_sub_y;
  logic               w_outline, w_cursor;
  logic [CW-1:0]      w_rgb;

  always_comb begin
    w_cell_x  = r_s1_fx >> CELL_SH;
    w_cell_y  = r_s1_fy >> CELL_SH;
    w_sub_x   = r_s1_fx[CELL_SH-1:0];
    w_sub_y   = r_s1_fy[CELL_SH-1:0];
    w_outline = (w_sub_x == '0) || (&w_sub_x) || (w_sub_y == '0) || (&w_sub_y);
    w_cursor  = r_cur_en && w_outline &&
                (int'(w_cell_x) == int'(r_cur_x)) && (int'(w_cell_y) == int'(r_cur_y));
    if (!r_s1_de)        w_rgb = '0;
    else if (w_cursor)   w_rgb = CUR_COLOR;
    else if (r_s1_in_fb) w_rgb = w_rdata;
    else                 w_rgb = BG_COLOR;
  end

  logic          r_hs, r_vs, r_de, r_fs;
  logic [CW-1:0] r_rgb;

  // frame_start is cleared on the very next clk, strobe or not, so it is one clk wide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_rgb <= '0;
      r_fs  <= 1'b0;
    end else begin
      r_fs <= pix_ce && r_s1_origin;
      if (pix_ce) begin
        r_hs  <= r_s1_hs ? HS_POL : ~HS_POL;
        r_vs  <= r_s1_vs ? VS_POL : ~VS_POL;
        r_de  <= r_s1_de;
        r_rgb <= w_rgb;
      end
    end
  end

  assign bus.hs          = r_hs;
  assign bus.vs          = r_vs;
  assign bus.de          = r_de;
  assign bus.rgb         = r_rgb;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - bench for vga_fb_scanout on a reduced 48x28 timing
module tb_vga_fb_scanout;
  import vga_fb_scanout_pkg::*;

  localparam int CW = 12, AW = 5, FB_W = 6, FB_H = 4;
  localparam int H_ACT = 32, H_FP = 4, H_SYN = 4, H_BP = 8, H_TOT = 48;
  localparam int V_ACT = 20, V_FP = 2, V_SYN = 2, V_BP = 4, V_TOT = 28;
  localparam color_t BG = 12'h00F, CUR = 12'hF00;

  typedef struct { int x; int y; logic hs; logic vs; logic de; logic fs; color_t rgb; } exp_t;
  typedef struct { int addr; color_t data; } wr_t;
  typedef struct { int f; int x; int y; color_t rgb; } probe_t;

  logic clk = 1'b0, rstn = 1'b0, pix_ce = 1'b0;
  vga_fb_scanout_if #(.CW(CW), .AW(AW)) bus();

  vga_fb_scanout #(
    .CW(CW), .AW(AW), .FB_W(FB_W), .FB_H(FB_H), .SCALE_SH(2), .CELL_SH(2),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .BG_COLOR(BG), .CUR_COLOR(CUR)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_ce(pix_ce), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int     errors = 0, checks = 0;
  exp_t   q[$];
  exp_t   cur_e, last_e;
  color_t mem [FB_W*FB_H];
  color_t cap [4][V_ACT][H_ACT];
  int     cnt_de[4], cnt_hs[4], cnt_vs[4];
  int     mh = 0, mv = 0, mcx = 0, mcy = 0, strobes = 0, fr = -1, first_hs = -1, fs_first = -1;
  bit     mcen = 1'b0, did_st;
  wr_t    wtab[4];
  probe_t ptab[27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int fx, fy;
    bit infb, cur;
    fx = h >> 2;
    fy = v >> 2;
    e.x  = h;
    e.y  = v;
    e.de = (h < H_ACT) && (v < V_ACT);
    e.hs = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYN);
    e.vs = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYN);
    e.fs = (h == 0) && (v == 0);
    infb = (fx < FB_W) && (fy < FB_H);
    cur  = mcen && (fx / 4 == mcx) && (fy / 4 == mcy) &&
           (fx % 4 == 0 || fx % 4 == 3 || fy % 4 == 0 || fy % 4 == 3);
    e.rgb = !e.de ? 12'h000 : cur ? CUR : infb ? mem[fy*FB_W + fx] : BG;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk($sformatf("%s_hs x%0d y%0d", tag, e.x, e.y), bus.hs, e.hs);
    chk($sformatf("%s_vs x%0d y%0d", tag, e.x, e.y), bus.vs, e.vs);
    chk($sformatf("%s_de x%0d y%0d", tag, e.x, e.y), bus.de, e.de);
    chk($sformatf("%s_rgb x%0d y%0d", tag, e.x, e.y), bus.rgb, e.rgb);
    chk($sformatf("%s_fs x%0d y%0d", tag, e.x, e.y), bus.frame_start, e.fs);
  endtask

  // Scoreboard: push the expected pixel at each strobe, pop two strobes later.
  initial forever begin
    @(posedge clk);
    did_st = 1'b0;
    if (!rstn) begin
      q.delete();
      mh = 0; mv = 0; mcen = 1'b0; mcx = 0; mcy = 0; strobes = 0; fs_first = -1;
      if (fr >= 0) fr = 2;
      last_e = '{x:0, y:0, hs:1'b0, vs:1'b0, de:1'b0, fs:1'b0, rgb:12'h000};
    end else if (pix_ce) begin
      if (mh == 0 && mv == 0) begin
        mcen = bus.cursor_en; mcx = int'(bus.cursor_x); mcy = int'(bus.cursor_y);
      end
      q.push_back(model(mh, mv));
      if (mh == H_TOT - 1) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else mh++;
      strobes++;
      did_st = 1'b1;
    end
    if (bus.we && int'(bus.waddr) < FB_W*FB_H) mem[bus.waddr] = bus.wdata;
    #1;
    if (rstn) begin
      if (did_st && q.size() >= 2) begin
        cur_e = q.pop_front();
        cmp_out("pix", cur_e);
        if (cur_e.fs) fr++;
        if (bus.frame_start && fs_first < 0) fs_first = strobes;
        if (fr >= 0 && fr < 4) begin
          if (cur_e.de) cap[fr][cur_e.y][cur_e.x] = bus.rgb;
          if (bus.de) cnt_de[fr]++;
          if (bus.hs) cnt_hs[fr]++;
          if (bus.vs) cnt_vs[fr]++;
        end
        if (fr == 0 && first_hs < 0 && bus.hs) first_hs = strobes;
        last_e = cur_e;
        last_e.fs = 1'b0;
      end else begin
        cmp_out("hold", last_e);
      end
    end
  end

  task automatic wr(input int addr, input color_t data);
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = AW'(addr); bus.wdata = data;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.cursor_en = 1'b0; bus.cursor_x = '0; bus.cursor_y = '0;
    rstn = 1'b0; pix_ce = 1'b1;
    wtab = '{'{0, 12'hABC}, '{1, 12'h123}, '{5, 12'h0F0}, '{24, 12'hEEE}};
    ptab = '{
      '{0, 0, 0, 12'hABC}, '{0, 3, 3, 12'hABC}, '{0, 4, 0, 12'h123}, '{0, 7, 3, 12'h123},
      '{0, 4, 4, 12'h207}, '{0, 20, 0, 12'hF00}, '{0, 20, 4, 12'h20B}, '{0, 16, 8, 12'hF00},
      '{0, 24, 8, 12'h00F}, '{0, 28, 8, 12'hF00}, '{0, 20, 12, 12'hF00}, '{0, 8, 16, 12'h00F},
      '{0, 12, 14, 12'h215},
      '{1, 20, 0, 12'h0F0}, '{1, 24, 0, 12'h00F}, '{1, 0, 16, 12'hF00}, '{1, 15, 19, 12'hF00},
      '{1, 16, 16, 12'h00F}, '{1, 20, 12, 12'h217},
      '{3, 8, 0, 12'h5A5}, '{3, 11, 3, 12'h5A5}, '{3, 0, 0, 12'hABC}, '{3, 4, 0, 12'h123},
      '{3, 20, 0, 12'h0F0}, '{3, 24, 0, 12'h00F}, '{3, 0, 16, 12'h00F}, '{3, 20, 12, 12'h217}
    };

    repeat (2) @(negedge clk);
    chk("rst_hs", bus.hs, 0);
    chk("rst_vs", bus.vs, 0);
    chk("rst_de", bus.de, 0);
    chk("rst_rgb", bus.rgb, 0);
    chk("rst_fs", bus.frame_start, 0);

    for (int i = 0; i < FB_W*FB_H; i++) wr(i, color_t'(12'h200 + i));
    foreach (wtab[i]) wr(wtab[i].addr, wtab[i].data);
    bus.cursor_en = 1'b1; bus.cursor_x = 8'd1; bus.cursor_y = 8'd0;
    @(negedge clk);
    rstn = 1'b1;

    repeat (400) @(negedge clk);
    bus.cursor_x = 8'd0; bus.cursor_y = 8'd1;
    for (int i = 0; i < 3000 && fr < 2; i++) @(negedge clk);
    chk("reach_frame2", fr >= 2, 1);
    chk("first_hs_strobe", first_hs, 38);
    chk("f0_de_count", cnt_de[0], 640);
    chk("f0_hs_count", cnt_hs[0], 112);
    chk("f0_vs_count", cnt_vs[0], 96);

    repeat (20) @(negedge clk);
    chk("pre_rst_de", bus.de, 1);
    rstn = 1'b0; pix_ce = 1'b0; bus.cursor_en = 1'b0;
    #1;
    chk("midrst_hs", bus.hs, 0);
    chk("midrst_vs", bus.vs, 0);
    chk("midrst_de", bus.de, 0);
    chk("midrst_rgb", bus.rgb, 0);
    chk("midrst_fs", bus.frame_start, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = AW'(2); bus.wdata = 12'h5A5;
    @(negedge clk);
    bus.we = 1'b0;
    for (int k = 0; k < 5000 && fr < 4; k++) begin
      pix_ce = (k % 3 == 0);
      @(negedge clk);
    end
    pix_ce = 1'b1;
    chk("reach_frame4", fr >= 4, 1);
    chk("fs_after_rst_strobe", fs_first, 2);
    chk("f3_de_count", cnt_de[3], 640);

    foreach (ptab[i])
      chk($sformatf("probe_f%0d_x%0d_y%0d", ptab[i].f, ptab[i].x, ptab[i].y),
          cap[ptab[i].f][ptab[i].y][ptab[i].x], ptab[i].rgb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
